// File: rtl/router_pkg.sv
// Shared types and sizing constants for the router switch slice.
package router_pkg;

  localparam int unsigned NPORTS = 4;
  localparam int unsigned PORT_W = $clog2(NPORTS);
  localparam int unsigned DROP_W = 8;

  typedef struct packed {
    logic [3:0]  src;
    logic [3:0]  dest;
    logic [23:0] data;
  } pkt_t;

endpackage

// File: rtl/router_switch_core_if.sv
// Handshake bundle between the switch core and its per-port input/output buffers.
interface router_switch_core_if #(
  parameter int unsigned NPORTS = router_pkg::NPORTS,
  parameter int unsigned DROP_W = router_pkg::DROP_W
);
  import router_pkg::*;

  logic [NPORTS-1:0]       in_avail;
  pkt_t [NPORTS-1:0]       in_pkt;
  logic [NPORTS-1:0]       in_taken;
  logic [NPORTS-1:0]       out_empty;
  logic [NPORTS-1:0]       out_wr;
  logic [NPORTS-1:0]       out_fill;
  pkt_t [NPORTS-1:0]       out_pkt;
  logic [DROP_W-1:0]       drop_cnt;

  // Buffer side.
  modport master (
    output in_avail, in_pkt, out_empty,
    input  in_taken, out_wr, out_fill, out_pkt, drop_cnt
  );

  // Switch side.
  modport slave (
    input  in_avail, in_pkt, out_empty,
    output in_taken, out_wr, out_fill, out_pkt, drop_cnt
  );

endinterface

// File: rtl/router_switch_core_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt
);

  logic         found;
  logic [W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_switch_core.sv
// Router central switch: steers complete packets from input buffers to output buffers,
// round-robin per output, dropping packets whose destination is out of range.
module router_switch_core #(
  parameter int unsigned NPORTS = router_pkg::NPORTS,
  parameter int unsigned PORT_W = router_pkg::PORT_W,
  parameter int unsigned DROP_W = router_pkg::DROP_W
) (
  input  logic                 clk,
  input  logic                 rst_b,
  router_switch_core_if.slave  bus
);
  import router_pkg::*;

  logic [NPORTS-1:0] dest_ok;
  logic [NPORTS-1:0] drop;
  logic [NPORTS-1:0] req     [NPORTS];
  logic [NPORTS-1:0] arb_gnt [NPORTS];
  logic [NPORTS-1:0] gnt     [NPORTS];
  logic [PORT_W-1:0] ptr     [NPORTS];
  logic [PORT_W-1:0] win     [NPORTS];
  logic [NPORTS-1:0] take_nxt;
  logic [PORT_W:0]   drop_n;
  logic [DROP_W:0]   drop_sum;

  // The registered pulses double as locks until the buffers catch up a cycle later.
  always_comb begin
    dest_ok = '0;
    drop    = '0;
    for (int unsigned j = 0; j < NPORTS; j++) req[j] = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      dest_ok[i] = 32'(bus.in_pkt[i].dest) < NPORTS;
      drop[i]    = bus.in_avail[i] && !bus.in_taken[i] && !dest_ok[i];
      for (int unsigned j = 0; j < NPORTS; j++)
        req[j][i] = bus.in_avail[i] && !bus.in_taken[i] && dest_ok[i]
                    && (bus.in_pkt[i].dest[PORT_W-1:0] == PORT_W'(j));
    end
  end

  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    rr_arbiter #(.N(NPORTS), .W(PORT_W)) u_arb (
      .req (req[j]),
      .ptr (ptr[j]),
      .gnt (arb_gnt[j])
    );
    assign gnt[j] = (bus.out_empty[j] && !bus.out_wr[j]) ? arb_gnt[j] : '0;
  end

  always_comb begin
    take_nxt = '0;
    drop_n   = '0;
    for (int unsigned j = 0; j < NPORTS; j++) begin
      win[j] = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (gnt[j][i]) begin
          win[j]      = PORT_W'(i);
          take_nxt[i] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NPORTS; i++)
      if (drop[i]) drop_n = drop_n + 1'b1;
    take_nxt = take_nxt | drop;
    drop_sum = {1'b0, bus.drop_cnt} + (DROP_W+1)'(drop_n);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bus.in_taken <= '0;
      bus.out_wr   <= '0;
      bus.out_fill <= '0;
      bus.out_pkt  <= '0;
      bus.drop_cnt <= '0;
      for (int unsigned j = 0; j < NPORTS; j++) ptr[j] <= '0;
    end else begin
      bus.in_taken <= take_nxt;
      bus.drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      for (int unsigned j = 0; j < NPORTS; j++) begin
        bus.out_wr[j]   <= |gnt[j];
        bus.out_fill[j] <= |gnt[j];
        if (|gnt[j]) begin
          bus.out_pkt[j] <= bus.in_pkt[win[j]];
          ptr[j]         <= (win[j] == PORT_W'(NPORTS-1)) ? '0 : win[j] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_switch_core.sv
// Directed + randomized bench for router_switch_core against a cycle-level reference model.
module tb_router_switch_core;
  import router_pkg::*;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  router_switch_core_if #(.NPORTS(4), .DROP_W(8)) bus ();

  router_switch_core #(.NPORTS(4), .PORT_W(2), .DROP_W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: pulses currently on the outputs, RR pointers, counters.
  int         m_ptr [4];
  logic [3:0] m_taken, m_wr;
  pkt_t [3:0] m_pkt;
  int         m_drop;
  logic [3:0] pend_taken, pend_fill;
  bit         auto_drain;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 4; j++) m_ptr[j] = 0;
    m_taken = '0; m_wr = '0; m_pkt = '0; m_drop = 0;
    pend_taken = '0; pend_fill = '0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    bus.in_avail = '0; bus.out_empty = '1; bus.in_pkt = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic load(input int i, input int dest, input int data);
    pkt_t p;
    p.src = 4'(i); p.dest = 4'(dest); p.data = 24'(data);
    bus.in_pkt[i]   = p;
    bus.in_avail[i] = 1'b1;
  endtask

  // One clock: predict from current inputs, take the edge, compare, then emulate buffers.
  task automatic step();
    logic [3:0] n_taken, n_wr;
    pkt_t [3:0] n_pkt;
    int n_ptr [4];
    int ndrop, i;
    bit found;
    n_taken = '0; n_wr = '0; n_pkt = m_pkt; ndrop = 0;
    for (int j = 0; j < 4; j++) n_ptr[j] = m_ptr[j];
    for (int k = 0; k < 4; k++)
      if (bus.in_avail[k] && !m_taken[k] && bus.in_pkt[k].dest >= 4) begin
        n_taken[k] = 1'b1; ndrop++;
      end
    for (int j = 0; j < 4; j++) begin
      found = 0;
      if (bus.out_empty[j] && !m_wr[j])
        for (int k = 0; k < 4; k++) begin
          i = (m_ptr[j] + k) % 4;
          if (!found && bus.in_avail[i] && !m_taken[i] && int'(bus.in_pkt[i].dest) == j) begin
            found = 1; n_wr[j] = 1'b1; n_taken[i] = 1'b1;
            n_pkt[j] = bus.in_pkt[i]; n_ptr[j] = (i + 1) % 4;
          end
        end
    end
    @(posedge clk); #1;
    m_taken = n_taken; m_wr = n_wr; m_pkt = n_pkt;
    for (int j = 0; j < 4; j++) m_ptr[j] = n_ptr[j];
    m_drop = (m_drop + ndrop > 255) ? 255 : m_drop + ndrop;
    chk("in_taken", 128'(bus.in_taken), 128'(m_taken));
    chk("out_wr",   128'(bus.out_wr),   128'(m_wr));
    chk("out_fill", 128'(bus.out_fill), 128'(m_wr));
    chk("out_pkt",  128'(bus.out_pkt),  128'(m_pkt));
    chk("drop_cnt", 128'(bus.drop_cnt), 128'(m_drop));
    bus.in_avail = bus.in_avail & ~pend_taken;
    if (!auto_drain) bus.out_empty = bus.out_empty & ~pend_fill;
    pend_taken = m_taken; pend_fill = m_wr;
  endtask

  initial begin
    int order [$];
    int ndrops;
    pkt_t p0;
    pkt_t [3:0] exp4;
    auto_drain = 0;

    // Reset state
    do_reset();
    chk("rst_in_taken", 128'(bus.in_taken), 128'(0));
    chk("rst_out_wr",   128'(bus.out_wr),   128'(0));
    chk("rst_out_pkt",  128'(bus.out_pkt),  128'(0));
    chk("rst_drop_cnt", 128'(bus.drop_cnt), 128'(0));

    // Single transfer in0 -> out2
    load(0, 2, 24'hABCDE1);
    p0 = bus.in_pkt[0];
    step();
    chk("t1_out_wr",   128'(bus.out_wr),   128'(4'b0100));
    chk("t1_in_taken", 128'(bus.in_taken), 128'(4'b0001));
    chk("t1_out_pkt2", 128'(bus.out_pkt[2]), 128'(p0));
    step();
    chk("t1_single_pulse", 128'(bus.out_wr), 128'(0));

    // Parallel: all four inputs to distinct empty outputs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(i, (i + 1) % 4, 24'h100 + i);
      exp4[(i + 1) % 4] = bus.in_pkt[i];
    end
    step();
    chk("t4_out_wr",   128'(bus.out_wr),   128'(4'hF));
    chk("t4_in_taken", 128'(bus.in_taken), 128'(4'hF));
    chk("t4_out_pkt",  128'(bus.out_pkt),  128'(exp4));
    step();

    // Contention on out1 from in0, in1, in3; output drains immediately
    do_reset();
    auto_drain = 1;
    load(0, 1, 24'h10); load(1, 1, 24'h11); load(3, 1, 24'h13);
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.out_wr[1])
        for (int i = 0; i < 4; i++) if (bus.in_taken[i]) order.push_back(i);
    end
    chk("t2_grants", 128'(order.size()), 128'(3));
    if (order.size() == 3) begin
      chk("t2_first",  128'(order[0]), 128'(0));
      chk("t2_second", 128'(order[1]), 128'(1));
      chk("t2_third",  128'(order[2]), 128'(3));
    end
    // Pointer wrapped back to 0: in0 wins again over in1
    load(0, 1, 24'h20); load(1, 1, 24'h21);
    step();
    chk("t2_wrap", 128'(bus.in_taken), 128'(4'b0001));
    repeat (3) step();
    auto_drain = 0;

    // Backpressure on out3
    do_reset();
    bus.out_empty[3] = 1'b0;
    load(2, 3, 24'h33);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t3_hold", 128'({bus.in_taken, bus.out_wr}), 128'(0));
    end
    bus.out_empty[3] = 1'b1;
    step();
    chk("t3_release_wr",    128'(bus.out_wr),   128'(4'b1000));
    chk("t3_release_taken", 128'(bus.in_taken), 128'(4'b0100));
    step();

    // Drops saturate the counter
    do_reset();
    ndrops = 0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.in_avail[1] && ndrops + (bus.in_taken[1] ? 1 : 0) < 300) load(1, 4, c);
      step();
      if (bus.in_taken[1]) ndrops++;
    end
    chk("t5_drops", 128'(ndrops), 128'(300));
    chk("t5_sat",   128'(bus.drop_cnt), 128'(8'hFF));

    // Reset during a pulse, then pointer restarts at 0
    do_reset();
    load(1, 1, 24'h55); load(0, 0, 24'h5);
    step();
    chk("t6_pre", 128'(bus.out_wr), 128'(4'b0011));
    #2 rst_b = 1'b0;
    #1;
    chk("t6_async_pulses", 128'({bus.in_taken, bus.out_wr, bus.out_fill}), 128'(0));
    chk("t6_async_pkt",    128'(bus.out_pkt),  128'(0));
    do_reset();
    load(1, 1, 24'h61); load(3, 1, 24'h63);
    step();
    chk("t6_ptr0", 128'(bus.in_taken), 128'(4'b0010));
    repeat (4) step();

    // Randomized traffic including invalid destinations and random draining
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!bus.in_avail[i] && !pend_taken[i] && ($urandom % 3) == 0)
          load(i, int'($urandom_range(0, 5)), int'($urandom));
      for (int j = 0; j < 4; j++)
        if (!bus.out_empty[j] && !pend_fill[j] && ($urandom % 4) == 0)
          bus.out_empty[j] = 1'b1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
